// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and the fetch-slot record for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
    localparam logic [4:0]  EXC_ADEL         = 5'h04;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        cancelled;
        logic        exc;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one fetch slot towards decode, at most one
// outstanding bus request, redirects cancel the slot instead of dropping data.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_accept,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] perfcnt_fetch_busy
);

    logic [31:0] fetch_pc;
    logic        outstanding;
    fetch_slot_t slot;
    logic [31:0] busy_cnt;

    logic aligned;
    logic can_issue;
    logic accepted;
    logic fault;

    // Outputs are gated by resetn so everything reads zero while reset is held.
    always_comb begin
        aligned   = (fetch_pc[1:0] == 2'b00);
        can_issue = !redirect_valid && (!outstanding || inst_data_ok) &&
                    (!slot.valid || dec_accept);
        inst_req  = resetn && can_issue && aligned;
        inst_addr = resetn ? fetch_pc : 32'h0;
        accepted  = inst_req && inst_addr_ok;
        fault     = can_issue && !aligned;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            slot        <= '0;
        end else begin
            if (accepted) begin
                slot     <= '{valid: 1'b1, pc: fetch_pc, cancelled: 1'b0, exc: 1'b0};
                fetch_pc <= fetch_pc + 32'd4;
            end else if (fault) begin
                slot     <= '{valid: 1'b1, pc: fetch_pc, cancelled: 1'b0, exc: 1'b1};
            end else if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                if (dec_accept) begin
                    slot.valid <= 1'b0;
                end else if (slot.valid) begin
                    slot.cancelled <= 1'b1;
                end
            end else if (dec_accept) begin
                slot.valid <= 1'b0;
            end

            if (accepted) begin
                outstanding <= 1'b1;
            end else if (inst_data_ok) begin
                outstanding <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_cnt <= 32'h0;
        end else if (outstanding && !inst_data_ok) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end

    assign valid_o            = slot.valid;
    assign pc_o               = slot.pc;
    assign cancelled_o        = slot.cancelled;
    assign exc_o              = slot.exc;
    assign exc_miss_o         = 1'b0;
    assign exccode_o          = slot.exc ? EXC_ADEL : 5'h00;
    assign perfcnt_fetch_busy = busy_cnt;

endmodule
